// File: rtl/util_pkg.sv
// Shared front-end types: the fetched packet format and instruction-queue defaults.
package util_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        taken_branch;
  } fetched_packet;

  localparam int IFQ_DEPTH = 8;

  // Scoreboard record: a packet tagged with the time it was pushed.
  typedef struct packed {
    fetched_packet pkt;
    logic [63:0]   sim_time;
  } ifq_entry_s;

endpackage

// File: rtl/if_id_queue_lane_compact.sv
// Packs valid fetch lanes toward lane 0 (keeping their order) and counts them.
module lane_compact
  import util_pkg::*;
(
  input  logic          [1:0] in_valid,
  input  fetched_packet [1:0] in_packet,
  output fetched_packet [1:0] packed_packet,
  output logic          [1:0] push_count
);

  always_comb begin
    packed_packet[0] = in_valid[0] ? in_packet[0] : in_packet[1];
    packed_packet[1] = in_packet[1];
    push_count       = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
  end

endmodule

// File: rtl/if_id_queue.sv
// Two-lane in-order queue between fetch and decode; registered outputs only,
// in_ready depends on stored count alone so decode backpressure never reaches fetch combinationally.
module if_id_queue
  import util_pkg::*;
#(
  parameter int DEPTH       = IFQ_DEPTH,
  parameter int INSTR_COUNT = 2,
  parameter int PACKET_SIZE = $bits(fetched_packet)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic          [INSTR_COUNT-1:0]  in_valid,
  input  fetched_packet [INSTR_COUNT-1:0]  in_packet,
  output logic                             in_ready,
  output logic          [INSTR_COUNT-1:0]  out_valid,
  output fetched_packet [INSTR_COUNT-1:0]  out_packet,
  input  logic                             out_ready,
  output logic          [$clog2(DEPTH):0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [CW-1:0]          count;
  logic [CW-1:0]          free_slots;

  fetched_packet [1:0]    compact_packet;
  logic          [1:0]    push_count;
  logic                   push;
  logic                   pop;
  logic          [1:0]    pop_count;
  logic          [CW-1:0] add_n;
  logic          [CW-1:0] sub_n;

  lane_compact u_lane_compact (
    .in_valid      (in_valid),
    .in_packet     (in_packet),
    .packed_packet (compact_packet),
    .push_count    (push_count)
  );

  assign free_slots = CW'(DEPTH) - count;
  assign in_ready   = free_slots >= CW'(INSTR_COUNT);
  assign occupancy  = count;

  assign out_valid[0] = count != '0;
  assign out_valid[1] = count > CW'(1);

  always_comb begin
    for (int i = 0; i < INSTR_COUNT; i++) begin
      out_packet[i] = fetched_packet'(mem[head + AW'(i)]);
    end
  end

  assign push      = in_ready && (|in_valid) && !flush;
  assign pop       = out_ready && out_valid[0] && !flush;
  assign pop_count = out_valid[1] ? 2'd2 : 2'd1;
  assign add_n     = push ? CW'(push_count) : '0;
  assign sub_n     = pop  ? CW'(pop_count)  : '0;

  // Storage is not reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= PACKET_SIZE'(compact_packet[0]);
      if (push_count == 2'd2) begin
        mem[tail + AW'(1)] <= PACKET_SIZE'(compact_packet[1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + AW'(push_count);
      end
      if (pop) begin
        head <= head + AW'(pop_count);
      end
      count <= count + add_n - sub_n;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: one task per scenario, inline checks, model queue for the wrap test.
module tb_if_id_queue;
  import util_pkg::*;

  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic          [1:0] in_valid;
  fetched_packet [1:0] in_packet;
  logic                in_ready;
  logic          [1:0] out_valid;
  fetched_packet [1:0] out_packet;
  logic                out_ready;
  logic          [3:0] occupancy;

  int tests_run = 0;
  int tests_failed = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_packet  (in_packet),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic ordy);
    in_valid = v;
    in_packet[0] = '{pc: pc0, data: ~pc0, taken_branch: pc0[2]};
    in_packet[1] = '{pc: pc1, data: ~pc1, taken_branch: pc1[2]};
    out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
    tests_run++;
    if (out_valid !== 2'b00) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 00", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_double_push();
    drive(2'b11, 32'h100, 32'h104, 1'b1);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    tests_run++;
    if (out_valid !== 2'b11) begin
      tests_failed++; $display("FAIL dbl_out_valid: got %b expected 11", out_valid);
    end
    tests_run++;
    if (out_packet[0].pc !== 32'h100 || out_packet[1].pc !== 32'h104) begin
      tests_failed++;
      $display("FAIL dbl_pcs: got %h/%h expected 100/104", out_packet[0].pc, out_packet[1].pc);
    end
    tests_run++;
    if (out_packet[0].data !== ~32'h100) begin
      tests_failed++; $display("FAIL dbl_data: got %h expected %h", out_packet[0].data, ~32'h100);
    end
    tick();
    tests_run++;
    if (occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL dbl_drain: got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_single_lane();
    drive(2'b10, 32'hdead, 32'h208, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests_run++;
    if (out_valid !== 2'b01) begin
      tests_failed++; $display("FAIL single_out_valid: got %b expected 01", out_valid);
    end
    tests_run++;
    if (out_packet[0].pc !== 32'h208) begin
      tests_failed++; $display("FAIL single_pc: got %h expected 208", out_packet[0].pc);
    end
    tests_run++;
    if (occupancy !== 4'd1) begin
      tests_failed++; $display("FAIL single_occ: got %0d expected 1", occupancy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (occupancy !== 4'd0 || out_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_pop: got occ %0d valid %b expected 0 00", occupancy, out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h400 + 32'(8 * i), 32'h404 + 32'(8 * i), 1'b0);
      tick();
    end
    tests_run++;
    if (occupancy !== 4'd6 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_six: got occ %0d rdy %b expected 6 1", occupancy, in_ready);
    end
    drive(2'b11, 32'h418, 32'h41c, 1'b0);
    tick();
    tests_run++;
    if (occupancy !== 4'd8 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_eight: got occ %0d rdy %b expected 8 0", occupancy, in_ready);
    end
    drive(2'b11, 32'h999, 32'h99c, 1'b0);
    tick();
    tests_run++;
    if (occupancy !== 4'd8) begin
      tests_failed++; $display("FAIL full_ignore: got %0d expected 8", occupancy);
    end
    tests_run++;
    if (out_packet[0].pc !== 32'h400) begin
      tests_failed++; $display("FAIL full_head: got %h expected 400", out_packet[0].pc);
    end
    // Decode pops 2 while count is 8; in_ready must stay low this cycle.
    drive(2'b11, 32'h999, 32'h99c, 1'b1);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_pop_rdy: got %b expected 0", in_ready);
    end
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    tests_run++;
    if (occupancy !== 4'd6 || out_packet[0].pc !== 32'h408) begin
      tests_failed++;
      $display("FAIL full_after_pop: got occ %0d pc %h expected 6 408", occupancy, out_packet[0].pc);
    end
    tick(); tick(); tick();
    out_ready = 1'b0;
    tests_run++;
    if (occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL full_drain: got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_wrap();
    // Each step is {in_valid[1:0], out_ready}; sequence gives odd head/tail so
    // two-lane writes and reads cross index 7 -> 0.
    logic [2:0] seq [20] = '{3'b100, 3'b001, 3'b110, 3'b110, 3'b110, 3'b111, 3'b001,
                             3'b110, 3'b001, 3'b110, 3'b001, 3'b100, 3'b001, 3'b111,
                             3'b011, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    ifq_entry_s q[$];
    logic [31:0] next_pc = 32'h1000;
    int          exp_n;
    logic [1:0]  exp_v;
    logic        ready_m;
    logic [1:0]  v;
    fetched_packet p0, p1;

    rst_n = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      exp_n = (q.size() >= 2) ? 2 : q.size();
      exp_v = (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00;
      tests_run++;
      if (out_valid !== exp_v) begin
        tests_failed++; $display("FAIL wrap_valid[%0d]: got %b expected %b", i, out_valid, exp_v);
      end
      for (int l = 0; l < exp_n; l++) begin
        tests_run++;
        if (out_packet[l].pc !== q[l].pkt.pc) begin
          tests_failed++;
          $display("FAIL wrap_pc[%0d] lane %0d: got %h expected %h", i, l, out_packet[l].pc, q[l].pkt.pc);
        end
      end
      ready_m = (DEPTH - q.size()) >= 2;
      v = seq[i][2:1];
      p0 = '{pc: v[0] ? next_pc : 32'hbad0, data: 32'h0, taken_branch: 1'b0};
      p1 = '{pc: v[1] ? (v[0] ? next_pc + 32'h4 : next_pc) : 32'hbad4, data: 32'h0,
             taken_branch: 1'b0};
      drive(v, p0.pc, p1.pc, seq[i][0]);
      tick();
      if (seq[i][0] && exp_n > 0) begin
        for (int l = 0; l < exp_n; l++) void'(q.pop_front());
      end
      if (ready_m) begin
        if (v[0]) begin q.push_back('{pkt: in_packet[0], sim_time: $time}); next_pc += 32'h4; end
        if (v[1]) begin q.push_back('{pkt: in_packet[1], sim_time: $time}); next_pc += 32'h4; end
      end
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests_run++;
    if (occupancy !== 4'(q.size()) || q.size() != 0) begin
      tests_failed++; $display("FAIL wrap_end_occ: got %0d expected %0d", occupancy, q.size());
    end
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h500, 32'h504, 1'b0); tick();
    drive(2'b11, 32'h508, 32'h50c, 1'b0); tick();
    drive(2'b01, 32'h510, 32'hbad, 1'b0); tick();
    tests_run++;
    if (occupancy !== 4'd5) begin
      tests_failed++; $display("FAIL flush_pre_occ: got %0d expected 5", occupancy);
    end
    flush = 1'b1;
    drive(2'b11, 32'hf00, 32'hf04, 1'b1);
    tick();
    flush = 1'b0;
    drive(2'b11, 32'h300, 32'h304, 1'b0);
    tests_run++;
    if (occupancy !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_state: got occ %0d valid %b rdy %b expected 0 00 1",
               occupancy, out_valid, in_ready);
    end
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests_run++;
    if (occupancy !== 4'd2 || out_packet[0].pc !== 32'h300 || out_packet[1].pc !== 32'h304) begin
      tests_failed++;
      $display("FAIL flush_repush: got occ %0d pcs %h/%h expected 2 300/304",
               occupancy, out_packet[0].pc, out_packet[1].pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (occupancy !== 4'd0) begin
      tests_failed++; $display("FAIL flush_drain: got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_reset_midstream();
    drive(2'b11, 32'h600, 32'h604, 1'b0); tick();
    drive(2'b10, 32'hbad, 32'h608, 1'b0); tick();
    tests_run++;
    if (occupancy !== 4'd3) begin
      tests_failed++; $display("FAIL rst_mid_pre: got %0d expected 3", occupancy);
    end
    rst_n = 1'b0;
    flush = 1'b1;
    drive(2'b11, 32'h700, 32'h704, 1'b1);
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests_run++;
    if (occupancy !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got occ %0d valid %b rdy %b expected 0 00 1",
               occupancy, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_double_push();
    test_single_lane();
    test_full();
    test_wrap();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
